fifo_to_axis_video: RTL
=======================

FIFO_TO_AXIS_VIDEO -- requirements
Module: fifo_to_axis_video

Interface
REQ-001 SHALL have parameter DATA_W, default 16, pixel width in bits.
REQ-002 SHALL have parameter H_ACTIVE, default 640, pixels per active line.
REQ-003 SHALL have parameter V_ACTIVE, default 480, lines per frame.
REQ-004 SHALL have port clk  input  1  single clock (capture-FIFO read clock); one clock, no other clock domains.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port fifo_empty  input  1  capture FIFO empty flag.
REQ-007 SHALL have port fifo_dout  input  DATA_W+2  FIFO word {vsync, href, pixel}, valid one cycle after fifo_rd_en.
REQ-008 SHALL have port fifo_rd_en  output  1  FIFO read strobe.
REQ-009 SHALL have ports m_axis_video_tdata (output, DATA_W), tvalid (output, 1), tready (input, 1), tuser (output, 1, start of frame), tlast (output, 1, end of line).
REQ-010 SHALL have port line_err  output  1  sticky flag: a malformed line or frame was seen.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse on the handshake of the last pixel of a frame.

Function
REQ-012 SHALL assert fifo_rd_en only when fifo_empty=0 and (output buffer occupancy + reads in flight) < 2.
REQ-013 SHALL capture fifo_dout exactly one cycle after each fifo_rd_en.
REQ-014 SHALL hold the output in a 2-entry buffer; tdata/tuser/tlast SHALL stay stable while tvalid=1 and tready=0.
REQ-015 SHALL transfer a beat only on tvalid=1 and tready=1; no beat SHALL be lost or duplicated under any tready pattern.
REQ-016 SHALL run an FSM with states SYNC, WAIT_VS_LOW and ACTIVE.
- SYNC: waits for a word with vsync=1, then goes to WAIT_VS_LOW.
- WAIT_VS_LOW: waits for a word with vsync=0, then goes to ACTIVE with x=0, y=0.
- ACTIVE: forwards data as defined below.
REQ-017 SHALL, in ACTIVE, discard words with href=0 and forward words with href=1 while x < H_ACTIVE.
REQ-018 SHALL set tuser=1 on the beat with x=0, y=0 only.
REQ-019 SHALL set tlast=1 on the beat with x=H_ACTIVE-1, then reset x to 0 and increment y.
REQ-020 SHALL drop href=1 words after tlast until href returns to 0, and set line_err.
REQ-021 SHALL treat href falling with 0 < x < H_ACTIVE as a short line: set line_err, reset x to 0, emit no tlast, leave y unchanged.
REQ-022 SHALL, after the tlast beat with y=V_ACTIVE-1, pulse frame_done on that beat's handshake and go to SYNC.
REQ-023 SHALL treat vsync=1 seen in ACTIVE before frame completion as an early frame: set line_err and go to WAIT_VS_LOW; buffered beats still drain.
REQ-024 SHALL size x and y with $clog2(H_ACTIVE) and $clog2(V_ACTIVE) bits; the counters SHALL never exceed H_ACTIVE-1 and V_ACTIVE-1.

Reset
REQ-025 SHALL, on reset_n=0, asynchronously set: FSM=SYNC, x=y=0, buffer empty, in-flight count 0, fifo_rd_en=0, tvalid=0, tuser=0, tlast=0, tdata=0, line_err=0, frame_done=0.
REQ-026 SHALL, on reset mid-frame, discard buffered beats and resynchronise on the next vsync.

Configuration
REQ-027 SHALL, with FRAME_COUNT_EN defined, add output frame_count [15:0], reset to 0, incremented on each frame_done and wrapping 0xFFFF to 0.
REQ-028 SHALL, without FRAME_COUNT_EN, omit the frame_count port and its logic entirely.

Structure
REQ-029 SHALL place the FSM state typedef, the FIFO word field positions and the default H_ACTIVE/V_ACTIVE constants in the shared package video_pkg.
REQ-030 SHALL implement the 2-entry output buffer as sub-module axis_skid_buf.

Verification (H_ACTIVE=4, V_ACTIVE=2)
REQ-031 Frame with tready held at 1: vsync pulse, then 2 lines of 4 href pixels 0x0001..0x0008 -> 8 beats in order; tuser only on 0x0001; tlast on 0x0004 and 0x0008; frame_done pulses once.
REQ-032 Same frame with tready toggling 1010... -> identical beat sequence; tdata stable while stalled; fifo_rd_en never violates REQ-012.
REQ-033 Line of 3 pixels then href=0 -> line_err=1; no tlast emitted; the next 4-pixel line carries tlast.
REQ-034 Line of 6 pixels -> 4 beats with tlast on the 4th; pixels 5 and 6 dropped; line_err=1.
REQ-035 vsync=1 after 1 line -> line_err=1; next frame's first beat has tuser=1; with FRAME_COUNT_EN, frame_count counts only completed frames.
REQ-036 reset_n pulsed low while 2 beats are buffered and tready=0 -> tvalid=0 immediately; outputs at reset values; recovery on the next frame.

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the capture-FIFO to AXI4-Stream video bridge:
// FSM encoding, FIFO word field positions and default frame geometry.
package video_pkg;

    typedef enum logic [1:0] {
        ST_SYNC        = 2'd0,
        ST_WAIT_VS_LOW = 2'd1,
        ST_ACTIVE      = 2'd2
    } vid_state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;

    // FIFO word is {vsync, href, pixel}; sync flags sit just above the pixel field
    localparam int HREF_OFS  = 0;
    localparam int VSYNC_OFS = 1;

    function automatic int href_pos(input int data_w);
        return data_w + HREF_OFS;
    endfunction

    function automatic int vsync_pos(input int data_w);
        return data_w + VSYNC_OFS;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry output buffer; the head entry stays put until it is handshaken,
// so the presented beat is stable under backpressure.
module axis_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic [1:0] w_count_next;
    logic       w_pop;

    assign o_valid = (r_count != 2'd0);
    assign w_pop   = o_valid & i_ready;
    assign o_count = r_count;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            logic [W-1:0] r_entry;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_entry <= '0;
                end else if (i_push && (r_wr_ptr == 1'(gi))) begin
                    r_entry <= i_data;
                end
            end
        end
    endgenerate

    assign o_data = r_rd_ptr ? g_entry[1].r_entry : g_entry[0].r_entry;

    always_comb begin
        w_count_next = r_count;
        case ({i_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= w_count_next;
        end
    end

endmodule

// File: rtl/fifo_to_axis_video.sv
// Converts capture-FIFO words {vsync, href, pixel} into an AXI4-Stream video
// stream with tuser/tlast framing. Define FRAME_COUNT_EN to add frame_count.
module fifo_to_axis_video
    import video_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fifo_empty,
    input  logic [DATA_W+1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_axis_video_tdata,
    output logic              m_axis_video_tvalid,
    input  logic              m_axis_video_tready,
    output logic              m_axis_video_tuser,
    output logic              m_axis_video_tlast,
    output logic              line_err,
    output logic              frame_done
`ifdef FRAME_COUNT_EN
    ,
    output logic [15:0]       frame_count
`endif
);
    localparam int X_W   = cnt_w(H_ACTIVE);
    localparam int Y_W   = cnt_w(V_ACTIVE);
    localparam int BUF_W = DATA_W + 3;
    localparam int VS_BIT = vsync_pos(DATA_W);
    localparam int HR_BIT = href_pos(DATA_W);
    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

    vid_state_t     r_state, w_state_next;
    logic [X_W-1:0] r_x, w_x_next;
    logic [Y_W-1:0] r_y, w_y_next;
    logic           r_drop, w_drop_next;
    logic           r_line_err, w_err_next;
    logic           r_rd_pending;

    logic              w_vsync, w_href;
    logic [DATA_W-1:0] w_pixel;
    logic              w_push, w_first, w_last, w_fend;
    logic [BUF_W-1:0]  w_buf_in, w_buf_out;
    logic [1:0]        w_occ;
    logic              w_valid;

    assign w_vsync = fifo_dout[VS_BIT];
    assign w_href  = fifo_dout[HR_BIT];
    assign w_pixel = fifo_dout[DATA_W-1:0];

    // Reads are throttled so every word in flight is guaranteed a buffer slot
    assign fifo_rd_en = reset_n & ~fifo_empty
                        & ((w_occ + {1'b0, r_rd_pending}) < 2'd2);

    always_comb begin
        w_state_next = r_state;
        w_x_next     = r_x;
        w_y_next     = r_y;
        w_drop_next  = r_drop;
        w_err_next   = r_line_err;
        w_push       = 1'b0;
        w_first      = 1'b0;
        w_last       = 1'b0;
        w_fend       = 1'b0;
        if (r_rd_pending) begin
            case (r_state)
                ST_SYNC: begin
                    if (w_vsync) w_state_next = ST_WAIT_VS_LOW;
                end
                ST_WAIT_VS_LOW: begin
                    if (!w_vsync) begin
                        w_state_next = ST_ACTIVE;
                        w_x_next     = '0;
                        w_y_next     = '0;
                        w_drop_next  = 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (w_vsync) begin
                        w_err_next   = 1'b1;
                        w_state_next = ST_WAIT_VS_LOW;
                    end else if (!w_href) begin
                        w_drop_next = 1'b0;
                        if (!r_drop && (r_x != '0)) begin
                            w_err_next = 1'b1;
                            w_x_next   = '0;
                        end
                    end else if (r_drop) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_push  = 1'b1;
                        w_first = (r_x == '0) && (r_y == '0);
                        w_last  = (r_x == X_LAST);
                        w_fend  = w_last && (r_y == Y_LAST);
                        if (w_last) begin
                            w_x_next    = '0;
                            w_drop_next = 1'b1;
                            if (r_y == Y_LAST) begin
                                w_y_next     = '0;
                                w_state_next = ST_SYNC;
                            end else begin
                                w_y_next = r_y + 1'b1;
                            end
                        end else begin
                            w_x_next = r_x + 1'b1;
                        end
                    end
                end
                default: w_state_next = ST_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_SYNC;
            r_x          <= '0;
            r_y          <= '0;
            r_drop       <= 1'b0;
            r_line_err   <= 1'b0;
            r_rd_pending <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_x          <= w_x_next;
            r_y          <= w_y_next;
            r_drop       <= w_drop_next;
            r_line_err   <= w_err_next;
            r_rd_pending <= fifo_rd_en;
        end
    end

    // The end-of-frame marker travels with the beat so frame_done lines up
    // with the handshake rather than with FIFO capture
    assign w_buf_in = {w_fend, w_first, w_last, w_pixel};

    axis_skid_buf #(
        .W (BUF_W)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (w_buf_in),
        .i_ready (m_axis_video_tready),
        .o_valid (w_valid),
        .o_data  (w_buf_out),
        .o_count (w_occ)
    );

    assign m_axis_video_tvalid = w_valid;
    assign m_axis_video_tdata  = w_buf_out[DATA_W-1:0];
    assign m_axis_video_tlast  = w_buf_out[DATA_W];
    assign m_axis_video_tuser  = w_buf_out[DATA_W+1];
    assign frame_done          = w_valid & m_axis_video_tready & w_buf_out[DATA_W+2];
    assign line_err            = r_line_err;

`ifdef FRAME_COUNT_EN
    logic [15:0] r_frame_count;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_count <= 16'd0;
        end else if (frame_done) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end
    assign frame_count = r_frame_count;
`endif

endmodule
